// File: rtl/jt5205_rom_seq.sv
// ADPCM nibble sequencer: prefetches ROM bytes over a cs/ok handshake
// and hands the JT5205 one nibble per sample strobe, high nibble first.
module jt5205_rom_seq #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          cen_lo,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] FULL = 2'd3;

    logic [1:0]    st_q, st_d;
    logic [AW-1:0] fp_q, fp_d;
    logic [AW-1:0] ep_q, ep_d;
    logic          lf_q, lf_d;
    logic [7:0]    hb_q, hb_d;
    logic          hv_q, hv_d;
    logic [3:0]    cb_q, cb_d;
    logic          ph_q, ph_d;
    logic          busy_q, busy_d;
    logic [3:0]    din_q, din_d;
    logic          done_q, done_d;
    logic          und_q, und_d;

    always_comb begin
        st_d   = st_q;
        fp_d   = fp_q;
        ep_d   = ep_q;
        lf_d   = lf_q;
        hb_d   = hb_q;
        hv_d   = hv_q;
        cb_d   = cb_q;
        ph_d   = ph_q;
        busy_d = busy_q;
        din_d  = din_q;
        done_d = 1'b0;
        und_d  = 1'b0;

        case (st_q)
            ADDR: st_d = WAIT;
            WAIT: begin
                if (rom_ok) begin
                    hb_d = rom_data;
                    hv_d = 1'b1;
                    lf_d = (fp_q == ep_q);
                    fp_d = fp_q + AW'(1);
                    st_d = FULL;
                end
            end
            FULL: begin
                if (!hv_q) st_d = lf_q ? IDLE : ADDR;
            end
            default: st_d = IDLE;
        endcase

        // Only the low nibble of the current byte is still needed after
        // the high nibble has been delivered.
        if (busy_q && cen_lo) begin
            if (ph_q) begin
                din_d = cb_q;
                ph_d  = 1'b0;
            end else if (hv_q) begin
                cb_d  = hb_q[3:0];
                hv_d  = 1'b0;
                din_d = hb_q[7:4];
                ph_d  = 1'b1;
            end else if (lf_q && st_q == IDLE) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                din_d  = 4'd0;
            end else begin
                und_d = 1'b1;
                din_d = 4'd0;
            end
        end

        if (stop && busy_q) begin
            busy_d = 1'b0;
            st_d   = IDLE;
            hv_d   = 1'b0;
            din_d  = 4'd0;
            done_d = 1'b0;
            und_d  = 1'b0;
        end

        // A new start abandons any fetch in flight; its data is dropped.
        if (start) begin
            fp_d   = start_addr;
            ep_d   = end_addr;
            lf_d   = 1'b0;
            hv_d   = 1'b0;
            ph_d   = 1'b0;
            busy_d = 1'b1;
            din_d  = 4'd0;
            st_d   = ADDR;
            done_d = 1'b0;
            und_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            fp_q   <= '0;
            ep_q   <= '0;
            lf_q   <= 1'b0;
            hb_q   <= 8'd0;
            hv_q   <= 1'b0;
            cb_q   <= 4'd0;
            ph_q   <= 1'b0;
            busy_q <= 1'b0;
            din_q  <= 4'd0;
            done_q <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            fp_q   <= fp_d;
            ep_q   <= ep_d;
            lf_q   <= lf_d;
            hb_q   <= hb_d;
            hv_q   <= hv_d;
            cb_q   <= cb_d;
            ph_q   <= ph_d;
            busy_q <= busy_d;
            din_q  <= din_d;
            done_q <= done_d;
            und_q  <= und_d;
        end
    end

    assign rom_addr = fp_q;
    assign rom_cs   = (st_q == ADDR) || (st_q == WAIT);
    assign din      = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_jt5205_rom_seq.sv
// Scoreboard bench for jt5205_rom_seq: strobes push expected outputs,
// a monitor pops and compares them the cycle after each strobe edge.
module tb_jt5205_rom_seq;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          cen_lo = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data = 8'd0;
    logic          rom_ok = 1'b0;
    logic [3:0]    din;
    logic          busy;
    logic          done;
    logic          underrun;

    jt5205_rom_seq #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr), .cen_lo(cen_lo),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
        .rom_ok(rom_ok), .din(din), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic       dn;
        logic       un;
        logic       b;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            rom_delay = 3;
    exp_t          expq[$];
    logic [AW-1:0] addr_log[$];

    int            rcnt = 0;
    logic          pcs = 1'b0;
    logic [AW-1:0] pa = '0;
    logic          mon_c = 1'b0;
    exp_t          mon_e;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        case (a)
            16'h0100: return 8'hA5;
            16'h0101: return 8'h3C;
            16'hFFFF: return 8'h4B;
            16'h0000: return 8'hD2;
            16'h0400: return 8'h9E;
            16'h0200: return 8'h77;
            16'h0300: return 8'h12;
            16'h0500: return 8'h6A;
            16'h0501: return 8'hB3;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // ROM: answers rom_delay cycles after a request (new address) appears.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rom_cs && pcs && rom_addr == pa) rcnt++;
            else rcnt = 0;
            if (rom_cs && !(pcs && rom_addr == pa)) addr_log.push_back(rom_addr);
            rom_ok = rom_cs && (rcnt >= rom_delay);
            rom_data = rom_cs ? rom_byte(rom_addr) : 8'h00;
            pcs = rom_cs;
            pa = rom_addr;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            mon_c = cen_lo;
            @(negedge clk);
            if (mon_c) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected din=%h done=%b und=%b",
                             din, done, underrun);
                end else begin
                    mon_e = expq.pop_front();
                    if ({din, done, underrun, busy} !== mon_e) begin
                        errors++;
                        $display("FAIL strobe got din=%h done=%b und=%b busy=%b want din=%h done=%b und=%b busy=%b",
                                 din, done, underrun, busy,
                                 mon_e.d, mon_e.dn, mon_e.un, mon_e.b);
                    end
                end
            end else if (done || underrun) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse got done=%b und=%b want 0 0",
                         done, underrun);
            end
        end
    end

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
        start_addr = s;
        end_addr = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy_cs", {30'd0, busy, rom_cs}, 32'd3);
    endtask

    task automatic strobe(input int gap, input logic [3:0] d,
                          input logic dn, input logic un, input logic b);
        exp_t e;
        repeat (gap - 1) @(negedge clk);
        e.d = d;
        e.dn = dn;
        e.un = un;
        e.b = b;
        expq.push_back(e);
        cen_lo = 1'b1;
        @(negedge clk);
        cen_lo = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_din", {28'd0, din}, 32'd0);
        check("rst_flags", {28'd0, busy, done, underrun, rom_cs}, 32'd0);
        check("rst_addr", {16'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        strobe(4, 4'h0, 1'b0, 1'b0, 1'b0);

        // basic play
        addr_log.delete();
        rom_delay = 3;
        do_start(16'h0100, 16'h0101);
        strobe(32, 4'hA, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h5, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h3, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'hC, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("basic_nreq", addr_log.size(), 32'd2);
        if (addr_log.size() == 2) begin
            check("basic_a0", {16'd0, addr_log[0]}, 32'h0100);
            check("basic_a1", {16'd0, addr_log[1]}, 32'h0101);
        end

        // wrap through the top of the address space
        addr_log.delete();
        do_start(16'hFFFF, 16'h0000);
        strobe(32, 4'h4, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'hB, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'hD, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h2, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_nreq", addr_log.size(), 32'd2);
        if (addr_log.size() == 2) begin
            check("wrap_a0", {16'd0, addr_log[0]}, 32'hFFFF);
            check("wrap_a1", {16'd0, addr_log[1]}, 32'h0000);
        end

        // underrun: slow ROM, byte lands between strobes 6 and 7
        rom_delay = 100;
        do_start(16'h0400, 16'h0400);
        for (int i = 0; i < 6; i++) strobe(16, 4'h0, 1'b0, 1'b1, 1'b1);
        strobe(16, 4'h9, 1'b0, 1'b0, 1'b1);
        strobe(16, 4'hE, 1'b0, 1'b0, 1'b1);
        strobe(16, 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // restart while the first fetch is answering
        rom_delay = 3;
        addr_log.delete();
        do_start(16'h0200, 16'h0200);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rom_ok) seen = 1'b1;
            else @(negedge clk);
        end
        check("restart_ok_seen", {31'd0, seen}, 32'd1);
        do_start(16'h0300, 16'h0300);
        strobe(32, 4'h1, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h2, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("restart_nreq", addr_log.size(), 32'd2);

        // stop after three nibbles, mid refill
        do_start(16'h0500, 16'h0503);
        strobe(32, 4'h6, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'hA, 1'b0, 1'b0, 1'b1);
        strobe(32, 4'hB, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("stop_cs_before", {31'd0, rom_cs}, 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_outs", {27'd0, din, busy}, 32'd0);
        check("stop_cs", {30'd0, rom_cs, done}, 32'd0);
        strobe(32, 4'h0, 1'b0, 1'b0, 1'b0);
        strobe(32, 4'h0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset during a fetch
        rom_delay = 100;
        do_start(16'h0600, 16'h0600);
        repeat (5) @(negedge clk);
        check("rstmid_cs_before", {31'd0, rom_cs}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_flags", {28'd0, busy, done, underrun, rom_cs}, 32'd0);
        check("rstmid_din_addr", {12'd0, din, rom_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        strobe(16, 4'h0, 1'b0, 1'b0, 1'b0);
        strobe(16, 4'h0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt5205_rom_seq.md
# jt5205_rom_seq

ADPCM sample sequencer sitting between the game ROM/SDRAM port and the JT5205 decoder. It accepts a start/end byte range and fetches bytes from ROM through a request/ok handshake, using a one-byte prefetch buffer. On every sample strobe from the JT5205 timing block it delivers the next 4-bit nibble, high nibble first. It reports busy, end-of-sample and underrun conditions to the sound CPU glue.

## Interface
- AW, 16: ROM byte address width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches start_addr/end_addr and begins playback.
- stop  in  1  one-cycle pulse; aborts playback.
- start_addr  in  AW  first byte address.
- end_addr  in  AW  last byte address (inclusive).
- cen_lo  in  1  sample-rate strobe from the timing block (already gated by cen).
- rom_addr  out  AW  ROM byte address.
- rom_cs  out  1  ROM request.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  ROM data valid for current rom_addr.
- din  out  4  nibble to the decoder.
- busy  out  1  playback active.
- done  out  1  one-cycle pulse at end of sample.
- underrun  out  1  one-cycle pulse when a nibble was due but no byte was buffered.

## Operation
- Registers: fetch pointer fp, end pointer ep, last-fetched flag lf, hold byte hb + valid hv, current byte cb, nibble phase ph.
- Fetch FSM states:
  - IDLE: rom_cs=0.
  - ADDR: rom_cs=1, rom_addr=fp, rom_ok ignored; lasts exactly 1 cycle, then WAIT.
  - WAIT: rom_cs=1; on rom_ok=1, hb<=rom_data, hv<=1, lf<=(fp==ep), fp<=fp+1 mod 2^AW, go to FULL.
  - FULL: rom_cs=0; when hv==0 and lf==0 go to ADDR; when hv==0 and lf==1 go to IDLE.
- start: fp<=start_addr, ep<=end_addr, lf<=0, hv<=0, ph<=0, busy<=1, din<=0, FSM<=ADDR. Any in-flight fetch is abandoned and its data is never stored.
- end_addr<start_addr: the fetch pointer wraps through 2^AW-1 to 0 and continues until end_addr is reached. start_addr==end_addr plays exactly one byte.
- Playback happens on cen_lo with busy=1, using register values from before the edge:
  - ph=0 and hv=1: cb<=hb, hv<=0, din<=hb[7:4], ph<=1.
  - ph=0, hv=0, lf=1, FSM in IDLE: done pulse, busy<=0, din<=0.
  - ph=0, hv=0, otherwise: underrun pulse, din<=0, ph unchanged, nothing consumed.
  - ph=1: din<=cb[3:0], ph<=0.
- stop with busy=1: busy<=0, FSM<=IDLE, hv<=0, din<=0, no done pulse. stop while idle is ignored.
- start and stop in the same cycle: start wins.
- start and cen_lo in the same cycle: start wins and cen_lo is ignored.
- cen_lo while busy=0: din stays 0, no pulses.

## Timing
- Reset values: rom_addr=0, rom_cs=0, din=0, busy=0, done=0, underrun=0, FSM=IDLE, hv=0, ph=0.
- start at cycle t: busy=1 and rom_cs=1 at t+1. The earliest byte capture is at t+2 (rom_ok sampled in WAIT).
- din, done and underrun update on the clock edge where cen_lo=1, so they are visible the following cycle.
- hv set by rom_ok in the same cycle as cen_lo is not seen by that cen_lo; that strobe underruns.
- The refill request (ADDR) starts the cycle after hv clears. Throughput is one byte per two cen_lo strobes.
- done and underrun are single-cycle pulses and never assert together.

## Test plan
- Basic play: start_addr=0x0100, end_addr=0x0101, ROM bytes 0xA5,0x3C, rom_ok 3 cycles after cs, cen_lo every 32 cycles → din sequence A,5,3,C; done on the 5th cen_lo; busy falls with it; rom_addr visits 0x0100 then 0x0101 only.
- Wrap: start_addr=0xFFFF, end_addr=0x0000 (AW=16) → fetches 0xFFFF then 0x0000, four nibbles, one done pulse.
- Underrun: rom_ok delayed 100 cycles, cen_lo every 16 cycles → underrun pulse on each strobe before the byte arrives, din=0 during those strobes; then normal nibbles with no nibble skipped.
- Restart mid-fetch: start at 0x0200, then start at 0x0300 while in WAIT; rom_ok returns 0x77 for the old address → 0x77 is never output; first nibble comes from byte 0x0300.
- Stop: stop after 3 nibbles → busy=0 next cycle, din=0, rom_cs=0, no done; later cen_lo strobes produce no pulses.
- Reset mid-play: assert rst asynchronously while rom_cs=1 → all outputs at reset values immediately; after release, cen_lo strobes produce nothing until start.
